// File: rtl/baccarat_fsm_if.sv
// Card-table control bundle: datapath scores in, card load strobes and result lights out.
// master is the sequencer side; slave is the card/score datapath side.
interface baccarat_fsm_if;
  logic [3:0] pscore;
  logic [3:0] dscore;
  logic [3:0] pcard3;
  logic       load_pcard1;
  logic       load_pcard2;
  logic       load_pcard3;
  logic       load_dcard1;
  logic       load_dcard2;
  logic       load_dcard3;
  logic       player_win_light;
  logic       dealer_win_light;
  logic       hand_done;

  modport master (
    input  pscore, dscore, pcard3,
    output load_pcard1, load_pcard2, load_pcard3,
    output load_dcard1, load_dcard2, load_dcard3,
    output player_win_light, dealer_win_light, hand_done
  );

  modport slave (
    output pscore, dscore, pcard3,
    input  load_pcard1, load_pcard2, load_pcard3,
    input  load_dcard1, load_dcard2, load_dcard3,
    input  player_win_light, dealer_win_light, hand_done
  );
endinterface

// File: rtl/baccarat_fsm.sv
// Baccarat hand sequencer: one load strobe per state, Moore outputs one cycle after each edge.
// No backpressure; DONE holds until resetb, lights track live scores while in DONE.
module baccarat_fsm (
  input  logic           slow_clock,
  input  logic           resetb,
  baccarat_fsm_if.master bus
);

  typedef enum logic [3:0] {
    IDLE, P1, D1, P2, D2, CHK, P3, CHKD, D3, DONE
  } state_t;

  state_t state, state_nxt;

  // Banker third-card table; face cards and tens count as zero.
  function automatic logic dealer_draws(input logic [3:0] ds, input logic [3:0] pc);
    logic [3:0] v;
    logic       draw;
    v    = (pc <= 4'd9) ? pc : 4'd0;
    draw = 1'b0;
    case (ds)
      4'd0, 4'd1, 4'd2: draw = 1'b1;
      4'd3:             draw = (v != 4'd8);
      4'd4:             draw = (v >= 4'd2) && (v <= 4'd7);
      4'd5:             draw = (v >= 4'd4) && (v <= 4'd7);
      4'd6:             draw = (v == 4'd6) || (v == 4'd7);
      default:          draw = 1'b0;
    endcase
    return draw;
  endfunction

  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: state_nxt = P1;
      P1:   state_nxt = D1;
      D1:   state_nxt = P2;
      P2:   state_nxt = D2;
      D2:   state_nxt = CHK;
      CHK: begin
        if (bus.pscore >= 4'd8 || bus.dscore >= 4'd8) state_nxt = DONE;
        else if (bus.pscore <= 4'd5)                   state_nxt = P3;
        else if (bus.dscore <= 4'd5)                   state_nxt = D3;
        else                                           state_nxt = DONE;
      end
      P3:   state_nxt = CHKD;
      CHKD: state_nxt = dealer_draws(bus.dscore, bus.pcard3) ? D3 : DONE;
      D3:   state_nxt = DONE;
      DONE: state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.load_pcard1      = (state == P1);
    bus.load_dcard1      = (state == D1);
    bus.load_pcard2      = (state == P2);
    bus.load_dcard2      = (state == D2);
    bus.load_pcard3      = (state == P3);
    bus.load_dcard3      = (state == D3);
    bus.hand_done        = (state == DONE);
    bus.player_win_light = 1'b0;
    bus.dealer_win_light = 1'b0;
    if (state == DONE) begin
      bus.player_win_light = (bus.pscore >= bus.dscore);
      bus.dealer_win_light = (bus.dscore >= bus.pscore);
    end
  end

endmodule

// File: tb/tb_baccarat_fsm.sv
// Directed bench for baccarat_fsm: per-edge output vectors checked against hand-derived tables.
module tb_baccarat_fsm;
  logic slow_clock = 1'b0;
  logic resetb     = 1'b0;
  int   checks     = 0;
  int   failures   = 0;

  baccarat_fsm_if bus();
  baccarat_fsm dut (.slow_clock(slow_clock), .resetb(resetb), .bus(bus));

  always #5 slow_clock = ~slow_clock;

  // {lp1, ld1, lp2, ld2, lp3, ld3, pwin, dwin, done}
  logic [8:0] outs;
  assign outs = {bus.load_pcard1, bus.load_dcard1, bus.load_pcard2, bus.load_dcard2,
                 bus.load_pcard3, bus.load_dcard3, bus.player_win_light,
                 bus.dealer_win_light, bus.hand_done};

  localparam logic [8:0] S_NONE = 9'b000000000;
  localparam logic [8:0] S_P1   = 9'b100000000;
  localparam logic [8:0] S_D1   = 9'b010000000;
  localparam logic [8:0] S_P2   = 9'b001000000;
  localparam logic [8:0] S_D2   = 9'b000100000;
  localparam logic [8:0] S_P3   = 9'b000010000;
  localparam logic [8:0] S_D3   = 9'b000001000;

  task automatic tick();
    @(posedge slow_clock);
    @(negedge slow_clock);
  endtask

  task automatic start_hand(input logic [3:0] p, input logic [3:0] d, input logic [3:0] c);
    @(negedge slow_clock);
    resetb     = 1'b0;
    bus.pscore = p;
    bus.dscore = d;
    bus.pcard3 = c;
    @(negedge slow_clock);
    resetb = 1'b1;
  endtask

  task automatic test_reset();
    bus.pscore = 4'd8;
    bus.dscore = 4'd9;
    bus.pcard3 = 4'd3;
    resetb     = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (outs !== S_NONE) begin
        failures++;
        $display("FAIL reset cycle%0d: got %b expected %b", i, outs, S_NONE);
      end
    end
  endtask

  task automatic test_natural();
    logic [8:0] exp_v [1:7];
    exp_v[1] = S_P1; exp_v[2] = S_D1; exp_v[3] = S_P2; exp_v[4] = S_D2;
    exp_v[5] = S_NONE; exp_v[6] = 9'b000000101; exp_v[7] = 9'b000000101;
    start_hand(4'd8, 4'd5, 4'd4);
    for (int i = 1; i <= 7; i++) begin
      tick();
      checks++;
      if (outs !== exp_v[i]) begin
        failures++;
        $display("FAIL natural edge%0d: got %b expected %b", i, outs, exp_v[i]);
      end
    end
  endtask

  task automatic test_strobe_order();
    logic [8:0] exp_v [1:6];
    exp_v[1] = S_P1; exp_v[2] = S_D1; exp_v[3] = S_P2; exp_v[4] = S_D2;
    exp_v[5] = S_NONE; exp_v[6] = 9'b000000011;
    start_hand(4'd6, 4'd7, 4'd2);
    for (int i = 1; i <= 6; i++) begin
      tick();
      checks++;
      if (outs !== exp_v[i]) begin
        failures++;
        $display("FAIL strobe_order edge%0d: got %b expected %b", i, outs, exp_v[i]);
      end
    end
  endtask

  task automatic test_player_stands();
    start_hand(4'd7, 4'd4, 4'd9);
    for (int i = 1; i <= 6; i++) tick();
    checks++;
    if (outs !== S_D3) begin
      failures++;
      $display("FAIL stand_d3 edge6: got %b expected %b", outs, S_D3);
    end
    bus.dscore = 4'd9;
    tick();
    checks++;
    if (outs !== 9'b000000011) begin
      failures++;
      $display("FAIL stand_done edge7: got %b expected %b", outs, 9'b000000011);
    end
  endtask

  task automatic test_dealer_rule();
    logic [3:0] tp [0:12];
    logic [3:0] td [0:12];
    logic [3:0] tc [0:12];
    logic       tdraw [0:12];
    logic [8:0] e;
    tp = '{4'd3, 4'd3, 4'd2, 4'd2, 4'd1, 4'd1, 4'd0, 4'd0, 4'd5, 4'd5, 4'd4, 4'd0, 4'd5};
    td = '{4'd6, 4'd6, 4'd3, 4'd3, 4'd4, 4'd4, 4'd5, 4'd5, 4'd6, 4'd6, 4'd7, 4'd2, 4'd5};
    tc = '{4'd7, 4'd12, 4'd8, 4'd9, 4'd1, 4'd2, 4'd4, 4'd3, 4'd6, 4'd8, 4'd7, 4'd8, 4'd13};
    tdraw = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int k = 0; k <= 12; k++) begin
      start_hand(tp[k], td[k], tc[k]);
      for (int i = 1; i <= 6; i++) tick();
      checks++;
      if (outs !== S_P3) begin
        failures++;
        $display("FAIL rule%0d_p3: got %b expected %b", k, outs, S_P3);
      end
      tick();
      checks++;
      if (outs !== S_NONE) begin
        failures++;
        $display("FAIL rule%0d_chkd: got %b expected %b", k, outs, S_NONE);
      end
      tick();
      e = tdraw[k] ? S_D3 : {6'b0, tp[k] >= td[k], td[k] >= tp[k], 1'b1};
      checks++;
      if (outs !== e) begin
        failures++;
        $display("FAIL rule%0d_edge8 p=%0d d=%0d c=%0d: got %b expected %b",
                 k, tp[k], td[k], tc[k], outs, e);
      end
      if (tdraw[k]) begin
        tick();
        e = {6'b0, tp[k] >= td[k], td[k] >= tp[k], 1'b1};
        checks++;
        if (outs !== e) begin
          failures++;
          $display("FAIL rule%0d_edge9: got %b expected %b", k, outs, e);
        end
      end
    end
  endtask

  task automatic test_tie();
    start_hand(4'd4, 4'd3, 4'd2);
    for (int i = 1; i <= 6; i++) tick();
    bus.pscore = 4'd6;
    tick();
    tick();
    checks++;
    if (outs !== S_D3) begin
      failures++;
      $display("FAIL tie_d3 edge8: got %b expected %b", outs, S_D3);
    end
    bus.dscore = 4'd6;
    tick();
    checks++;
    if (outs !== 9'b000000111) begin
      failures++;
      $display("FAIL tie_done edge9: got %b expected %b", outs, 9'b000000111);
    end
  endtask

  task automatic test_async_reset();
    logic [8:0] exp_v [1:6];
    exp_v[1] = S_P1; exp_v[2] = S_D1; exp_v[3] = S_P2; exp_v[4] = S_D2;
    exp_v[5] = S_NONE; exp_v[6] = S_P3;
    start_hand(4'd3, 4'd6, 4'd7);
    for (int i = 1; i <= 6; i++) tick();
    checks++;
    if (outs !== S_P3) begin
      failures++;
      $display("FAIL areset_pre: got %b expected %b", outs, S_P3);
    end
    #2 resetb = 1'b0;
    #1;
    checks++;
    if (outs !== S_NONE) begin
      failures++;
      $display("FAIL areset_drop: got %b expected %b", outs, S_NONE);
    end
    tick();
    resetb = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick();
      checks++;
      if (outs !== exp_v[i]) begin
        failures++;
        $display("FAIL areset_restart edge%0d: got %b expected %b", i, outs, exp_v[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_natural();
    test_strobe_order();
    test_player_stands();
    test_dealer_rule();
    test_tie();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
